mbscore_mem_access: RTL and testbench
=====================================

MBSCORE_MEM_ACCESS -- requirements
Module: mbscore_mem_access

Interface
REQ-001: Parameter DATA_WIDTH, default 32, data path width; only 32 is supported.
REQ-002: Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003: Parameter TIMEOUT, default 255, maximum number of BUS-state cycles without mem_ack (range 1..255).
REQ-004: clk  in  1  single clock; all state changes on the rising edge.
REQ-005: rst_n  in  1  reset, asynchronous and active-low.
REQ-006: req_valid  in  1  pipeline access request; req_ready  out  1  request accepted when both are high.
REQ-007: req_we  in  1  (1 = store, 0 = load); req_size  in  2  (0 = byte, 1 = half, 2 or 3 = word); req_sext  in  1  sign-extend load data.
REQ-008: req_addr  in  ADDR_WIDTH  byte address; req_wdata  in  DATA_WIDTH  store data, right-aligned.
REQ-009: rsp_valid  out  1  completion strobe; rsp_rdata  out  DATA_WIDTH  load result, right-aligned; rsp_err  out  1  access failed.
REQ-010: mem_req  out  1; mem_we  out  1; mem_addr  out  ADDR_WIDTH, word-aligned; mem_be  out  4; mem_wdata  out  DATA_WIDTH.
REQ-011: mem_ack  in  1  one-cycle bus completion; mem_rdata  in  DATA_WIDTH  read word, valid with mem_ack.

Function
REQ-012: The FSM SHALL have states IDLE, BUS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-013: On acceptance in IDLE, the block SHALL register we/size/sext/addr/wdata and enter BUS on the next edge, unless REQ-024 applies.
REQ-014: In BUS, mem_req SHALL be 1, with mem_we/mem_addr/mem_be/mem_wdata held stable until mem_ack.
REQ-015: mem_addr SHALL be {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-016: Byte store: mem_wdata = wdata[7:0] replicated to all four lanes; mem_be = 4'b0001 << addr[1:0].
REQ-017: Half store: mem_wdata = wdata[15:0] replicated twice; mem_be = 4'b0011 when addr[1] = 0, otherwise 4'b1100.
REQ-018: Word access: mem_be = 4'b1111; loads SHALL drive mem_be exactly as a store of the same size would.
REQ-019: mem_ack in BUS SHALL move the FSM to RESP; a load SHALL capture its lane(s) of mem_rdata, zero- or sign-extended per sext.
REQ-020: RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; stores give rsp_rdata = 0.
REQ-021: Latency: accept at edge N, mem_req high in cycle N+1; mem_ack sampled at edge M gives rsp_valid in cycle M+1; minimum accept-to-accept spacing is 3 cycles.
REQ-022: A timeout counter SHALL clear on BUS entry and increment each BUS cycle without mem_ack; when it reaches TIMEOUT, mem_req SHALL deassert and the FSM SHALL enter RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-023: mem_ack outside BUS SHALL be ignored; mem_ack arriving on the timeout cycle SHALL win, with rsp_err = 0.

Reset
REQ-025: While rst_n = 0: FSM = IDLE, req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0, counter = 0.
REQ-026: Reset during BUS SHALL drop mem_req immediately (asynchronously); no response SHALL be issued for the aborted access.
REQ-027: req_ready SHALL first assert in the cycle after rst_n deasserts.

Configuration
REQ-024: With MBSCORE_MISALIGN_TRAP_EN defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, SHALL skip BUS (no mem_req), enter RESP directly, and give rsp_err = 1 with rsp_rdata = 0.
REQ-028: Without MBSCORE_MISALIGN_TRAP_EN: misaligned accesses SHALL proceed with forced alignment (half uses addr[1] only; word uses all lanes), and rsp_err SHALL be raised only by timeout.

Verification
REQ-029: Word load to addr 0x100, mem_ack one cycle after mem_req, mem_rdata = 0xDEADBEEF -> mem_addr = 0x100, mem_be = 4'b1111, rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid 2 cycles after mem_req first rises.
REQ-030: Byte load at addr 0x103, sext = 1, mem_rdata = 0x80000000 -> mem_be = 4'b1000, rsp_rdata = 0xFFFFFF80; same access with sext = 0 -> 0x00000080.
REQ-031: Half store at addr 0x202, wdata = 0x1234ABCD -> mem_be = 4'b1100, mem_wdata = 0xABCDABCD, mem_we = 1, rsp_valid with rsp_rdata = 0.
REQ-032: No mem_ack, TIMEOUT = 4 -> mem_req high for 4 cycles then low, rsp_valid with rsp_err = 1, rsp_rdata = 0, req_ready high the following cycle.
REQ-033: Word load at addr 0x101 -> with the macro: no mem_req, rsp_err = 1 one cycle after accept; without it: mem_addr = 0x100, normal completion.
REQ-034: rst_n pulsed low while mem_req is high -> mem_req low in the same cycle, no rsp_valid, and a new request is accepted normally afterwards.

Source files
------------

// File: rtl/mbscore_mem_access.sv
// Load/store unit: turns one pipeline access into one word-aligned bus transaction with byte lanes and a timeout.
// Optional feature: define MBSCORE_MISALIGN_TRAP_EN to trap misaligned half/word accesses without touching the bus.
module mbscore_mem_access #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_sext,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [1:0]            lo_q, lo_d;
  logic                  trap_c;

  logic                  req_ready_d, rsp_valid_d, rsp_err_d, mem_req_d, mem_we_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [3:0]            mem_be_d;

  // Lane enables for a given size and low address bits; loads use the same pattern as stores.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b1111;
    if (size == 2'd0)      be = 4'b0001 << lo;
    else if (size == 2'd1) be = lo[1] ? 4'b1100 : 4'b0011;
    return be;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [1:0] size,
                                                       input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] w;
    w = wd;
    if (size == 2'd0)      w = {4{wd[7:0]}};
    else if (size == 2'd1) w = {2{wd[15:0]}};
    return w;
  endfunction

  // Right-align the addressed lane(s) of the read word and extend.
  function automatic logic [DATA_WIDTH-1:0] lane_rdata(input logic [1:0] size, input logic sext,
                                                       input logic [1:0] lo,
                                                       input logic [DATA_WIDTH-1:0] rd);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    r = rd;
    if (size == 2'd0)      r = {{24{sext & b[7]}}, b};
    else if (size == 2'd1) r = {{16{sext & h[15]}}, h};
    return r;
  endfunction

`ifdef MBSCORE_MISALIGN_TRAP_EN
  assign trap_c = ((req_size == 2'd1) && req_addr[0]) ||
                  (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign trap_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lo_d        = lo_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          size_d      = req_size;
          sext_d      = req_sext;
          lo_d        = req_addr[1:0];
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_be_d    = lane_be(req_size, req_addr[1:0]);
          mem_wdata_d = lane_wdata(req_size, req_wdata);
          cnt_d       = '0;
          if (trap_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = BUS;
            mem_req_d = 1'b1;
          end
        end
      end
      BUS: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_we ? '0 : lane_rdata(size_q, sext_q, lo_q, mem_rdata);
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = RESP;
          cnt_d       = cnt_q + CNT_W'(1);
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      lo_q      <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      lo_q      <= lo_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mbscore_mem_access.sv
// Self-checking bench for mbscore_mem_access: directed vector table, random accesses against a lane model, reset corners.
module tb_mbscore_mem_access;

  localparam int unsigned TO = 4;
`ifdef MBSCORE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_sext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_vec = 0;
  int n_err = 0;

  mbscore_mem_access #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;     // BUS cycle index carrying mem_ack; >= TO means never
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_trap;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int delay, input logic [3:0] be,
                              input logic [31:0] ewd, input logic [31:0] erd,
                              input logic err, input logic trap);
    vec_t v;
    v.we = we; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.delay = delay; v.exp_be = be; v.exp_wdata = ewd;
    v.exp_rdata = erd; v.exp_err = err; v.exp_trap = trap;
    return v;
  endfunction

  // Reference: byte-lane arithmetic on the address, independent of any state machine.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int unsigned off, hsel;
    logic [31:0] lane;
    r    = v;
    off  = v.addr % 4;
    hsel = (v.addr / 2) % 2;
    r.exp_trap = TRAP_EN && (((v.size == 2'd1) && (off % 2 != 0)) || ((v.size >= 2'd2) && (off != 0)));
    if (v.size == 2'd0) begin
      r.exp_be    = 4'(1 << off);
      r.exp_wdata = (v.wdata & 32'hFF) * 32'h0101_0101;
      lane = (v.rdata >> (8 * off)) & 32'hFF;
      if (v.sext && lane >= 32'd128) lane = lane - 32'd256;
    end else if (v.size == 2'd1) begin
      r.exp_be    = 4'(3 << (2 * hsel));
      r.exp_wdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
      lane = (v.rdata >> (16 * hsel)) & 32'hFFFF;
      if (v.sext && lane >= 32'd32768) lane = lane - 32'd65536;
    end else begin
      r.exp_be    = 4'hF;
      r.exp_wdata = v.wdata;
      lane = v.rdata;
    end
    r.exp_err   = r.exp_trap || (v.delay >= int'(TO));
    r.exp_rdata = (v.we || r.exp_err) ? 32'h0 : lane;
    return r;
  endfunction

  task automatic run_access(input vec_t v);
    bit acked;
    @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_sext = v.sext;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    if (v.exp_trap) begin
      check("trap_mem_req", 32'(mem_req), 32'd0);
      check("trap_rsp_valid", 32'(rsp_valid), 32'd1);
      check("trap_rsp_err", 32'(rsp_err), 32'd1);
      check("trap_rsp_rdata", rsp_rdata, 32'h0);
    end else begin
      acked = 1'b0;
      for (int k = 0; k < int'(TO); k++) begin
        check("bus_mem_req", 32'(mem_req), 32'd1);
        check("bus_ready_low", 32'(req_ready), 32'd0);
        check("bus_rsp_valid", 32'(rsp_valid), 32'd0);
        check("bus_mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        check("bus_mem_be", 32'(mem_be), 32'(v.exp_be));
        check("bus_mem_we", 32'(mem_we), 32'(v.we));
        if (v.we) check("bus_mem_wdata", mem_wdata, v.exp_wdata);
        if (k == v.delay) begin
          mem_ack = 1'b1; mem_rdata = v.rdata; acked = 1'b1;
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (acked) break;
      end
      check("rsp_mem_req", 32'(mem_req), 32'd0);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      check("rsp_rdata", rsp_rdata, v.exp_rdata);
    end
    @(negedge clk);
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check("ready_after_rsp", 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    //         we    sz    sx    addr          wdata         rdata         dly  be     exp_wdata     exp_rdata                    err      trap
    tbl[0] = mk(1'b0, 2'd2, 1'b0, 32'h100, 32'h0,         32'hDEADBEEF, 1,  4'hF, 32'h0,        32'hDEADBEEF,               1'b0,    1'b0);
    tbl[1] = mk(1'b0, 2'd0, 1'b1, 32'h103, 32'h0,         32'h80000000, 0,  4'h8, 32'h0,        32'hFFFFFF80,               1'b0,    1'b0);
    tbl[2] = mk(1'b0, 2'd0, 1'b0, 32'h103, 32'h0,         32'h80000000, 0,  4'h8, 32'h0,        32'h00000080,               1'b0,    1'b0);
    tbl[3] = mk(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 32'h0,        0,  4'hC, 32'hABCDABCD, 32'h0,                      1'b0,    1'b0);
    tbl[4] = mk(1'b0, 2'd2, 1'b0, 32'h040, 32'h0,         32'h55555555, 99, 4'hF, 32'h0,        32'h0,                      1'b1,    1'b0);
    tbl[5] = mk(1'b0, 2'd3, 1'b0, 32'h101, 32'h0,         32'h11223344, 0,  4'hF, 32'h0,        TRAP_EN ? 32'h0 : 32'h11223344, TRAP_EN, TRAP_EN);
    tbl[6] = mk(1'b0, 2'd1, 1'b1, 32'h001, 32'h0,         32'h7FFF8000, 2,  4'h3, 32'h0,        TRAP_EN ? 32'h0 : 32'hFFFF8000, TRAP_EN, TRAP_EN);
    tbl[7] = mk(1'b0, 2'd2, 1'b0, 32'h008, 32'h0,         32'hCAFEF00D, 3,  4'hF, 32'h0,        32'hCAFEF00D,               1'b0,    1'b0);
    tbl[8] = mk(1'b1, 2'd0, 1'b0, 32'h001, 32'h000000A5, 32'h0,        1,  4'h2, 32'hA5A5A5A5, 32'h0,                      1'b0,    1'b0);
    tbl[9] = mk(1'b1, 2'd2, 1'b0, 32'h010, 32'h01234567, 32'h0,        2,  4'hF, 32'h01234567, 32'h0,                      1'b0,    1'b0);

    // Reset values while rst_n is held low.
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    check("ready_same_cycle_as_release", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_cycle_after_release", 32'(req_ready), 32'd1);

    // A stray mem_ack while idle must not produce a response.
    mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_ack_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_ack_mem_req", 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;

    foreach (tbl[i]) run_access(tbl[i]);

    // Reset in the middle of a bus access drops mem_req at once and issues no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_mem_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_req_async", 32'(mem_req), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    mem_ack = 1'b0;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_abort_ready", 32'(req_ready), 32'd1);
    end
    run_access(tbl[3]);

    // Random accesses checked against the lane model.
    for (int i = 0; i < 60; i++) begin
      rv.we    = 1'($urandom_range(0, 1));
      rv.size  = 2'($urandom_range(0, 3));
      rv.sext  = 1'($urandom_range(0, 1));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.delay = int'($urandom_range(0, TO + 1));
      run_access(model(rv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
